bsg_plic_claim_arbiter: RTL and testbench



---
 rtl/bsg_plic_claim_arbiter.sv | 81 ++++++++
 tb/tb_bsg_plic_claim_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_plic_claim_arbiter.sv
// rtl/bsg_plic_claim_arbiter.sv - PLIC gateway and claim/complete arbiter for one target
module bsg_plic_claim_arbiter #(
    parameter int num_src_p = 2,
    parameter int prio_width_p = 3,
    localparam int id_width_lp = $clog2(num_src_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_src_p-1:0]              src_i,
    input  logic [num_src_p*prio_width_p-1:0] priority_i,
    input  logic [num_src_p-1:0]              enable_i,
    input  logic [prio_width_p-1:0]           threshold_i,
    input  logic                              claim_v_i,
    output logic [id_width_lp-1:0]            claim_id_o,
    input  logic                              complete_v_i,
    input  logic [id_width_lp-1:0]            complete_id_i,
    output logic [num_src_p-1:0]              pending_o,
    output logic                              irq_o
);

    typedef enum logic [1:0] {IDLE, PENDING, CLAIMED} gw_state_e;

    gw_state_e               state_q [num_src_p];
    gw_state_e               state_d [num_src_p];
    logic [id_width_lp-1:0]  winner_q, winner_d;
    logic                    irq_q;
    logic [id_width_lp-1:0]  best_id;
    logic [prio_width_p-1:0] best_prio;
    logic                    claim_fire;

    // Strict '>' on priority keeps the lowest ID on ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int k = 0; k < num_src_p; k++) begin
            if (state_q[k] == PENDING && enable_i[k]
                && priority_i[k*prio_width_p +: prio_width_p] > threshold_i
                && (best_id == '0 || priority_i[k*prio_width_p +: prio_width_p] > best_prio)) begin
                best_id   = id_width_lp'(k + 1);
                best_prio = priority_i[k*prio_width_p +: prio_width_p];
            end
        end
    end

    // A claim against an empty winner is a no-op and must not disturb state.
    assign claim_fire = claim_v_i && (winner_q != '0);
    assign winner_d   = claim_fire ? '0 : best_id;

    always_comb begin
        for (int k = 0; k < num_src_p; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                IDLE:    if (src_i[k]) state_d[k] = PENDING;
                PENDING: if (claim_fire && winner_q == id_width_lp'(k + 1)) state_d[k] = CLAIMED;
                CLAIMED: if (complete_v_i && complete_id_i == id_width_lp'(k + 1)) state_d[k] = IDLE;
                default: state_d[k] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < num_src_p; k++) state_q[k] <= IDLE;
            winner_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            for (int k = 0; k < num_src_p; k++) state_q[k] <= state_d[k];
            winner_q <= winner_d;
            irq_q    <= (winner_d != '0);
        end
    end

    always_comb begin
        pending_o = '0;
        for (int k = 0; k < num_src_p; k++) pending_o[k] = (state_q[k] == PENDING);
    end

    assign claim_id_o = winner_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_bsg_plic_claim_arbiter.sv
// tb/tb_bsg_plic_claim_arbiter.sv - scoreboard bench for bsg_plic_claim_arbiter
module tb_bsg_plic_claim_arbiter;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [1:0] src_i = '0;
    logic [5:0] priority_i = '0;
    logic [1:0] enable_i = '0;
    logic [2:0] threshold_i = '0;
    logic       claim_v_i = 1'b0;
    logic [1:0] claim_id_o;
    logic       complete_v_i = 1'b0;
    logic [1:0] complete_id_i = '0;
    logic [1:0] pending_o;
    logic       irq_o;

    int checks = 0;
    int failures = 0;
    logic [4:0] exp_q [$];

    bsg_plic_claim_arbiter #(.num_src_p(2), .prio_width_p(3)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .src_i(src_i), .priority_i(priority_i),
        .enable_i(enable_i), .threshold_i(threshold_i), .claim_v_i(claim_v_i),
        .claim_id_o(claim_id_o), .complete_v_i(complete_v_i),
        .complete_id_i(complete_id_i), .pending_o(pending_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cfg(input logic [2:0] p1, input logic [2:0] p2,
                       input logic [1:0] en, input logic [2:0] th);
        priority_i  = {p2, p1};
        enable_i    = en;
        threshold_i = th;
    endtask

    // stim row: {reset, src[1:0], claim, complete_v, complete_id[1:0]}
    // exp row:  {irq, claim_id[1:0], pending[1:0]}
    task automatic test_reset();
        logic [6:0] stim [2] = '{7'b1_00_0_0_00, 7'b1_11_1_0_00};
        logic [4:0] expv [2] = '{5'b0_00_00, 5'b0_00_00};
        logic [4:0] e;
        cfg(3'd1, 3'd1, 2'b11, 3'd0);
        for (int i = 0; i < 2; i++) begin
            {reset_i, src_i, claim_v_i, complete_v_i, complete_id_i} = stim[i];
            exp_q.push_back(expv[i]);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            checks++;
            if ({irq_o, claim_id_o, pending_o} !== e) begin
                failures++;
                $display("FAIL reset[%0d] got=%b want=%b", i, {irq_o, claim_id_o, pending_o}, e);
            end
        end
    endtask

    task automatic test_source_rise();
        logic [6:0] stim [5] = '{7'b0_01_0_0_00, 7'b0_01_0_0_00, 7'b0_01_1_0_00,
                                 7'b0_00_0_1_01, 7'b0_00_0_0_00};
        logic [4:0] expv [5] = '{5'b0_00_01, 5'b1_01_01, 5'b0_00_00, 5'b0_00_00, 5'b0_00_00};
        logic [4:0] e;
        cfg(3'd2, 3'd5, 2'b11, 3'd0);
        for (int i = 0; i < 5; i++) begin
            {reset_i, src_i, claim_v_i, complete_v_i, complete_id_i} = stim[i];
            exp_q.push_back(expv[i]);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            checks++;
            if ({irq_o, claim_id_o, pending_o} !== e) begin
                failures++;
                $display("FAIL source_rise[%0d] got=%b want=%b", i, {irq_o, claim_id_o, pending_o}, e);
            end
        end
    endtask

    task automatic test_priority(input logic [2:0] p1, input logic [2:0] p2,
                                 input logic [1:0] first, input logic [1:0] second);
        logic [6:0] stim [7] = '{7'b1_00_0_0_00, 7'b0_11_0_0_00, 7'b0_11_0_0_00,
                                 7'b0_11_1_0_00, 7'b0_11_0_0_00, 7'b0_11_1_0_00,
                                 7'b0_11_0_0_00};
        logic [1:0] rem = (first == 2'd1) ? 2'b10 : 2'b01;
        logic [4:0] expv [7];
        logic [4:0] e;
        expv = '{5'b0_00_00, 5'b0_00_11, {1'b1, first, 2'b11}, {3'b000, rem},
                 {1'b1, second, rem}, 5'b0_00_00, 5'b0_00_00};
        cfg(p1, p2, 2'b11, 3'd0);
        for (int i = 0; i < 7; i++) begin
            {reset_i, src_i, claim_v_i, complete_v_i, complete_id_i} = stim[i];
            exp_q.push_back(expv[i]);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            checks++;
            if ({irq_o, claim_id_o, pending_o} !== e) begin
                failures++;
                $display("FAIL priority_%0d_%0d[%0d] got=%b want=%b", p1, p2, i,
                         {irq_o, claim_id_o, pending_o}, e);
            end
        end
    endtask

    task automatic test_threshold();
        logic [6:0] stim [6] = '{7'b1_00_0_0_00, 7'b0_11_0_0_00, 7'b0_11_0_0_00,
                                 7'b0_11_0_0_00, 7'b0_11_0_0_00, 7'b0_11_0_0_00};
        logic [4:0] expv [6] = '{5'b0_00_00, 5'b0_00_11, 5'b0_00_11, 5'b0_00_11,
                                 5'b1_01_11, 5'b1_01_11};
        logic [4:0] e;
        cfg(3'd5, 3'd3, 2'b11, 3'd5);
        for (int i = 0; i < 6; i++) begin
            if (i == 4) threshold_i = 3'd2;
            {reset_i, src_i, claim_v_i, complete_v_i, complete_id_i} = stim[i];
            exp_q.push_back(expv[i]);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            checks++;
            if ({irq_o, claim_id_o, pending_o} !== e) begin
                failures++;
                $display("FAIL threshold[%0d] got=%b want=%b", i, {irq_o, claim_id_o, pending_o}, e);
            end
        end
    endtask

    task automatic test_hold_claim();
        logic [6:0] stim [9] = '{7'b1_00_0_0_00, 7'b0_01_0_0_00, 7'b0_01_0_0_00,
                                 7'b0_01_1_0_00, 7'b0_01_0_0_00, 7'b0_01_0_0_00,
                                 7'b0_01_0_1_01, 7'b0_01_0_0_00, 7'b0_01_0_0_00};
        logic [4:0] expv [9] = '{5'b0_00_00, 5'b0_00_01, 5'b1_01_01, 5'b0_00_00,
                                 5'b0_00_00, 5'b0_00_00, 5'b0_00_00, 5'b0_00_01,
                                 5'b1_01_01};
        logic [4:0] e;
        cfg(3'd5, 3'd1, 2'b11, 3'd0);
        for (int i = 0; i < 9; i++) begin
            {reset_i, src_i, claim_v_i, complete_v_i, complete_id_i} = stim[i];
            exp_q.push_back(expv[i]);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            checks++;
            if ({irq_o, claim_id_o, pending_o} !== e) begin
                failures++;
                $display("FAIL hold_claim[%0d] got=%b want=%b", i, {irq_o, claim_id_o, pending_o}, e);
            end
        end
    endtask

    task automatic test_ignored_ops();
        logic [6:0] stim [10] = '{7'b1_00_0_0_00, 7'b0_11_0_0_00, 7'b0_11_0_0_00,
                                  7'b0_11_1_0_00, 7'b0_11_0_1_00, 7'b0_11_0_1_11,
                                  7'b0_11_0_1_10, 7'b0_11_1_0_00, 7'b0_11_0_0_00,
                                  7'b0_11_0_0_00};
        logic [4:0] expv [10] = '{5'b0_00_00, 5'b0_00_11, 5'b1_01_11, 5'b0_00_10,
                                  5'b0_00_10, 5'b0_00_10, 5'b0_00_10, 5'b0_00_10,
                                  5'b0_00_10, 5'b1_10_10};
        logic [4:0] e;
        cfg(3'd5, 3'd6, 2'b01, 3'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) enable_i = 2'b11;
            {reset_i, src_i, claim_v_i, complete_v_i, complete_id_i} = stim[i];
            exp_q.push_back(expv[i]);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            checks++;
            if ({irq_o, claim_id_o, pending_o} !== e) begin
                failures++;
                $display("FAIL ignored_ops[%0d] got=%b want=%b", i, {irq_o, claim_id_o, pending_o}, e);
            end
        end
    endtask

    task automatic test_reset_mid_claim();
        logic [6:0] stim [6] = '{7'b1_00_0_0_00, 7'b0_01_0_0_00, 7'b0_01_0_0_00,
                                 7'b1_01_1_0_00, 7'b0_01_0_0_00, 7'b0_01_0_0_00};
        logic [4:0] expv [6] = '{5'b0_00_00, 5'b0_00_01, 5'b1_01_01, 5'b0_00_00,
                                 5'b0_00_01, 5'b1_01_01};
        logic [4:0] e;
        cfg(3'd5, 3'd2, 2'b11, 3'd0);
        for (int i = 0; i < 6; i++) begin
            {reset_i, src_i, claim_v_i, complete_v_i, complete_id_i} = stim[i];
            exp_q.push_back(expv[i]);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            checks++;
            if ({irq_o, claim_id_o, pending_o} !== e) begin
                failures++;
                $display("FAIL reset_mid_claim[%0d] got=%b want=%b", i, {irq_o, claim_id_o, pending_o}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_source_rise();
        test_priority(3'd3, 3'd6, 2'd2, 2'd1);
        test_priority(3'd4, 3'd4, 2'd1, 2'd2);
        test_threshold();
        test_hold_claim();
        test_ignored_ops();
        test_reset_mid_claim();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
